// File: rtl/ram_port_pkg.sv
// Shared constants for the dual-port RAM initiator: FSM state encoding and default widths.
package ram_port_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WRITE   = 3'd1;
    localparam logic [2:0] ST_WR_LAST = 3'd2;
    localparam logic [2:0] ST_READ    = 3'd3;
    localparam logic [2:0] ST_TURN    = 3'd4;

endpackage

// File: rtl/ram_port_master.sv
// Burst initiator for one port of the dual-port RAM: converts client command/write/read streams
// into registered address, data, we and oe activity on the shared tristate data bus.
module ram_port_master
    import ram_port_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  mem_oe
);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_oe_q, mem_oe_d;
    logic                  drv_en_q, drv_en_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    // Handshakes: a transfer happens on a rising edge where both valid and ready are high;
    // valid never depends on ready, and ready is held low while reset is asserted.
    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign wr_ready  = (state_q == ST_WRITE) && !reset;

    assign busy        = (state_q != ST_IDLE);
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign mem_address = mem_address_q;
    assign mem_we      = mem_we_q;
    assign mem_oe      = mem_oe_q;
    assign mem_data    = drv_en_q ? wdata_q : {DATA_WIDTH{1'bz}};

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        count_d       = count_q;
        mem_address_d = mem_address_q;
        mem_we_d      = 1'b0;
        mem_oe_d      = 1'b0;
        drv_en_d      = 1'b0;
        wdata_d       = wdata_q;
        rd_valid_d    = rd_valid_q && !rd_ready;
        rd_data_d     = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    count_d = cmd_len;
                    if (cmd_we) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d       = ST_READ;
                        mem_oe_d      = 1'b1;
                        mem_address_d = cmd_addr;
                    end
                end
            end
            ST_WRITE: begin
                // Accepted beat goes on the bus next cycle; no beat means a bubble with the bus released.
                if (wr_valid) begin
                    mem_we_d      = 1'b1;
                    drv_en_d      = 1'b1;
                    wdata_d       = wr_data;
                    mem_address_d = addr_q;
                    addr_d        = addr_q + 1'b1;
                    count_d       = count_q - 1'b1;
                    if (count_q == '0) begin
                        state_d = ST_WR_LAST;
                    end
                end
            end
            ST_WR_LAST: begin
                state_d = ST_IDLE;
            end
            ST_READ: begin
                mem_oe_d = 1'b1;
                // Capture only when the output register is free or being consumed this edge.
                if (!rd_valid_q || rd_ready) begin
                    rd_data_d     = mem_data;
                    rd_valid_d    = 1'b1;
                    addr_d        = addr_q + 1'b1;
                    count_d       = count_q - 1'b1;
                    mem_address_d = addr_q + 1'b1;
                    if (count_q == '0) begin
                        state_d  = ST_TURN;
                        mem_oe_d = 1'b0;
                    end
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            count_q       <= '0;
            mem_address_q <= '0;
            mem_we_q      <= 1'b0;
            mem_oe_q      <= 1'b0;
            drv_en_q      <= 1'b0;
            wdata_q       <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            count_q       <= count_d;
            mem_address_q <= mem_address_d;
            mem_we_q      <= mem_we_d;
            mem_oe_q      <= mem_oe_d;
            drv_en_q      <= drv_en_d;
            wdata_q       <= wdata_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

endmodule
